// File: rtl/dvp_pattern_gen.sv
// ----------------------------------------------------------------------------
// dvp_pattern_gen
// Stand-in for an OV5640-style camera on the DVP byte bus. It emits frames of
// RGB565 test patterns, two bytes per pixel with the high byte first, so the
// capture / Sobel / UDP chain can be brought up on known images.
//
// Parameters (all must be >= 1):
//   V_SYNC  - cycles o_cam_vsync is high per frame
//   V_BACK  - idle cycles between vsync fall and the first line
//   H_BLANK - idle cycles after every line, including the last
//   V_FRONT - idle cycles after the last line's blank
//
// Ports:
//   i_clk          single clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_start        frame request, honoured only while idle
//   i_cont         high at frame end -> next frame follows immediately
//   i_cmos_h       pixels per line (0 blocks a start)
//   i_cmos_v       lines per frame (0 blocks a start)
//   i_pattern      00 line index, 01 gray ramp, 10 colour bars, 11 checker
//   o_cam_vsync    frame sync, active high
//   o_cam_href     line valid, active high
//   o_cam_data     pixel byte, zero outside lines
//   o_busy         high whenever a frame is in progress
//   o_frame_done   one-cycle pulse on the final front-porch cycle
// ----------------------------------------------------------------------------
module dvp_pattern_gen #(
   parameter int V_SYNC  = 4,
   parameter int V_BACK  = 8,
   parameter int H_BLANK = 30,
   parameter int V_FRONT = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_cont,
   input  logic [15:0] i_cmos_h,
   input  logic [15:0] i_cmos_v,
   input  logic [1:0]  i_pattern,
   output logic        o_cam_vsync,
   output logic        o_cam_href,
   output logic [7:0]  o_cam_data,
   output logic        o_busy,
   output logic        o_frame_done
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_VSYNC, ST_VBACK, ST_LINE, ST_HBLANK, ST_VFRONT
   } state_t;

   localparam logic [15:0] LP_VSYNC_LAST  = 16'(V_SYNC - 1);
   localparam logic [15:0] LP_VBACK_LAST  = 16'(V_BACK - 1);
   localparam logic [15:0] LP_HBLANK_LAST = 16'(H_BLANK - 1);
   localparam logic [15:0] LP_VFRONT_LAST = 16'(V_FRONT - 1);
   localparam logic [15:0] LP_VFRONT_PRE  = 16'(V_FRONT - 2);

   state_t      r_state;
   logic [15:0] r_phase;
   logic [15:0] r_x;
   logic        r_b;
   logic [15:0] r_y;
   logic [15:0] r_h;
   logic [15:0] r_v;
   logic [1:0]  r_pat;
   logic        r_vsync;
   logic        r_href;
   logic [7:0]  r_data;
   logic        r_busy;
   logic        r_frame_done;

   logic [15:0] w_next_x;
   logic [15:0] w_next_y;
   logic [15:0] w_pix_cur;
   logic [15:0] w_pix_next;
   logic [15:0] w_pix_row0;
   logic [15:0] w_pix_nrow;
   logic        w_dims_ok;

   // RGB565 value of pixel (x, y) for the given pattern.
   function automatic logic [15:0] f_pixel(input logic [1:0] pat,
                                           input logic [15:0] x,
                                           input logic [15:0] y);
      logic [7:0] g;
      logic [2:0] bar;
      g   = x[7:0];
      bar = x[6:4];
      case (pat)
         2'b00:   f_pixel = {y[7:0], y[7:0]};
         2'b01:   f_pixel = {g[7:3], g[7:2], g[7:3]};
         2'b10:   f_pixel = {{5{bar[2]}}, {6{bar[1]}}, {5{bar[0]}}};
         default: f_pixel = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      endcase
   endfunction

   assign w_next_x   = r_x + 16'd1;
   assign w_next_y   = r_y + 16'd1;
   assign w_pix_cur  = f_pixel(r_pat, r_x, r_y);
   assign w_pix_next = f_pixel(r_pat, w_next_x, r_y);
   assign w_pix_row0 = f_pixel(r_pat, 16'd0, r_y);
   assign w_pix_nrow = f_pixel(r_pat, 16'd0, w_next_y);
   assign w_dims_ok  = (i_cmos_h != 16'd0) && (i_cmos_v != 16'd0);

   // Outputs are registered together with the state: every transition also
   // loads the output values that belong to the state being entered.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_phase      <= 16'd0;
         r_x          <= 16'd0;
         r_b          <= 1'b0;
         r_y          <= 16'd0;
         r_h          <= 16'd0;
         r_v          <= 16'd0;
         r_pat        <= 2'b00;
         r_vsync      <= 1'b0;
         r_href       <= 1'b0;
         r_data       <= 8'd0;
         r_busy       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start && w_dims_ok) begin
                  r_h     <= i_cmos_h;
                  r_v     <= i_cmos_v;
                  r_pat   <= i_pattern;
                  r_phase <= 16'd0;
                  r_vsync <= 1'b1;
                  r_busy  <= 1'b1;
                  r_state <= ST_VSYNC;
               end
            end
            ST_VSYNC: begin
               if (r_phase == LP_VSYNC_LAST) begin
                  r_phase <= 16'd0;
                  r_vsync <= 1'b0;
                  r_state <= ST_VBACK;
               end else begin
                  r_phase <= r_phase + 16'd1;
               end
            end
            ST_VBACK: begin
               if (r_phase == LP_VBACK_LAST) begin
                  r_x     <= 16'd0;
                  r_b     <= 1'b0;
                  r_href  <= 1'b1;
                  r_data  <= w_pix_row0[15:8];
                  r_state <= ST_LINE;
               end else begin
                  r_phase <= r_phase + 16'd1;
               end
            end
            ST_LINE: begin
               if (!r_b) begin
                  r_b    <= 1'b1;
                  r_data <= w_pix_cur[7:0];
               end else if (r_x == r_h - 16'd1) begin
                  r_b     <= 1'b0;
                  r_phase <= 16'd0;
                  r_href  <= 1'b0;
                  r_data  <= 8'd0;
                  r_state <= ST_HBLANK;
               end else begin
                  r_x    <= w_next_x;
                  r_b    <= 1'b0;
                  r_data <= w_pix_next[15:8];
               end
            end
            ST_HBLANK: begin
               if (r_phase != LP_HBLANK_LAST) begin
                  r_phase <= r_phase + 16'd1;
               end else if (r_y == r_v - 16'd1) begin
                  r_phase      <= 16'd0;
                  r_frame_done <= (V_FRONT == 1);
                  r_state      <= ST_VFRONT;
               end else begin
                  r_y     <= w_next_y;
                  r_x     <= 16'd0;
                  r_href  <= 1'b1;
                  r_data  <= w_pix_nrow[15:8];
                  r_state <= ST_LINE;
               end
            end
            ST_VFRONT: begin
               if (r_phase == LP_VFRONT_LAST) begin
                  r_phase <= 16'd0;
                  r_x     <= 16'd0;
                  r_y     <= 16'd0;
                  // A zero dimension on the re-latch ends the run cleanly.
                  if (i_cont && w_dims_ok) begin
                     r_h     <= i_cmos_h;
                     r_v     <= i_cmos_v;
                     r_pat   <= i_pattern;
                     r_vsync <= 1'b1;
                     r_state <= ST_VSYNC;
                  end else begin
                     r_busy  <= 1'b0;
                     r_state <= ST_IDLE;
                  end
               end else begin
                  r_phase      <= r_phase + 16'd1;
                  // Raise the pulse as we step into the last front-porch cycle.
                  r_frame_done <= (r_phase == LP_VFRONT_PRE);
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_cam_vsync  = r_vsync;
   assign o_cam_href   = r_href;
   assign o_cam_data   = r_data;
   assign o_busy       = r_busy;
   assign o_frame_done = r_frame_done;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// ----------------------------------------------------------------------------
// tb_dvp_pattern_gen
// Drives dvp_pattern_gen with directed and randomized frames and compares every
// output cycle against a per-cycle expectation stream built from the frame
// timing rules and the pattern formulas using plain integer arithmetic.
// Expectation word per cycle: {frame_done, busy, vsync, href, data[7:0]}.
// ----------------------------------------------------------------------------
module tb_dvp_pattern_gen;

   localparam int P_VSYNC  = 4;
   localparam int P_VBACK  = 8;
   localparam int P_HBLANK = 30;
   localparam int P_VFRONT = 8;

   logic        clk;
   logic        i_rst;
   logic        i_start;
   logic        i_cont;
   logic [15:0] i_cmos_h;
   logic [15:0] i_cmos_v;
   logic [1:0]  i_pattern;
   logic        o_cam_vsync;
   logic        o_cam_href;
   logic [7:0]  o_cam_data;
   logic        o_busy;
   logic        o_frame_done;

   int          n_chk;
   int          n_bad;
   int          fd_idx;
   logic [31:0] exp_q[$];
   int          cur_h;
   int          cur_v;
   int          cur_pat;

   dvp_pattern_gen #(
      .V_SYNC (P_VSYNC),
      .V_BACK (P_VBACK),
      .H_BLANK(P_HBLANK),
      .V_FRONT(P_VFRONT)
   ) dut (
      .i_clk       (clk),
      .i_rst       (i_rst),
      .i_start     (i_start),
      .i_cont      (i_cont),
      .i_cmos_h    (i_cmos_h),
      .i_cmos_v    (i_cmos_v),
      .i_pattern   (i_pattern),
      .o_cam_vsync (o_cam_vsync),
      .o_cam_href  (o_cam_href),
      .o_cam_data  (o_cam_data),
      .o_busy      (o_busy),
      .o_frame_done(o_frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_word();
      return {20'd0, o_frame_done, o_busy, o_cam_vsync, o_cam_href, o_cam_data};
   endfunction

   // Reference pixel value, from the pattern rules in integer arithmetic.
   function automatic int ref_pix(input int pat, input int x, input int y);
      int g;
      int bar;
      int p;
      case (pat)
         0: p = ((y % 256) * 256) + (y % 256);
         1: begin
            g = x % 256;
            p = ((g / 8) * 2048) + ((g / 4) * 32) + (g / 8);
         end
         2: begin
            bar = (x / 16) % 8;
            p = (((bar / 4) % 2 == 1) ? 31 * 2048 : 0)
              + (((bar / 2) % 2 == 1) ? 63 * 32 : 0)
              + ((bar % 2 == 1) ? 31 : 0);
         end
         default: p = (((x / 8) % 2) != ((y / 8) % 2)) ? 65535 : 0;
      endcase
      return p;
   endfunction

   function automatic logic [31:0] mk(input int fd, input int busy, input int vs,
                                      input int hr, input int data);
      return 32'(fd * 2048 + busy * 1024 + vs * 512 + hr * 256 + data);
   endfunction

   // Append one frame's worth of expected cycles.
   task automatic add_frame(input int h, input int v, input int pat);
      int p;
      for (int i = 0; i < P_VSYNC; i++) exp_q.push_back(mk(0, 1, 1, 0, 0));
      for (int i = 0; i < P_VBACK; i++) exp_q.push_back(mk(0, 1, 0, 0, 0));
      for (int y = 0; y < v; y++) begin
         for (int x = 0; x < h; x++) begin
            p = ref_pix(pat, x, y);
            exp_q.push_back(mk(0, 1, 0, 1, p / 256));
            exp_q.push_back(mk(0, 1, 0, 1, p % 256));
         end
         for (int i = 0; i < P_HBLANK; i++) exp_q.push_back(mk(0, 1, 0, 0, 0));
      end
      for (int i = 0; i < P_VFRONT; i++)
         exp_q.push_back(mk((i == P_VFRONT - 1) ? 1 : 0, 1, 0, 0, 0));
   endtask

   // Request a frame: inputs set on a falling edge, start sampled next rise.
   task automatic kick(input int h, input int v, input int pat, input bit cont);
      @(negedge clk);
      cur_h     = h;
      cur_v     = v;
      cur_pat   = pat;
      i_cmos_h  = 16'(h);
      i_cmos_v  = 16'(v);
      i_pattern = 2'(pat);
      i_cont    = cont;
      i_start   = 1'b1;
   endtask

   // Compare n cycles of the expectation queue. Optionally pulse start at
   // random, scramble the geometry inputs before scr_end, drop cont at drop_at.
   task automatic run_stream(input int n, input bit rnd_start, input int scr_end,
                             input int drop_at);
      logic [31:0] obs;
      fd_idx = -1;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         obs = obs_word();
         if (obs[11] && fd_idx < 0) fd_idx = k;
         chk($sformatf("cyc%0d", k), obs, exp_q[k]);
         i_start = (rnd_start && k < n - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (k < scr_end) begin
            i_cmos_h  = 16'($urandom_range(0, 300));
            i_cmos_v  = 16'($urandom_range(0, 300));
            i_pattern = 2'($urandom_range(0, 3));
         end else if (k == scr_end) begin
            i_cmos_h  = 16'(cur_h);
            i_cmos_v  = 16'(cur_v);
            i_pattern = 2'(cur_pat);
         end
         if (k == drop_at) i_cont = 1'b0;
      end
      i_start = 1'b0;
   endtask

   task automatic single_frame(input int h, input int v, input int pat, input bit rnd);
      exp_q.delete();
      add_frame(h, v, pat);
      $display("frame h=%0d v=%0d pat=%0d cycles=%0d", h, v, pat, exp_q.size());
      kick(h, v, pat, 1'b0);
      run_stream(exp_q.size(), rnd, rnd ? exp_q.size() / 2 : 0, -1);
      @(negedge clk);
      chk("post_idle", obs_word(), 32'd0);
   endtask

   task automatic idle_check(input string tag, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         i_start = 1'b0;
         chk(tag, obs_word(), 32'd0);
      end
   endtask

   initial begin
      int len1;
      int line5;
      n_chk     = 0;
      n_bad     = 0;
      i_rst     = 1'b1;
      i_start   = 1'b0;
      i_cont    = 1'b0;
      i_cmos_h  = 16'd0;
      i_cmos_v  = 16'd0;
      i_pattern = 2'b00;
      cur_h     = 0;
      cur_v     = 0;
      cur_pat   = 0;

      repeat (2) @(negedge clk);
      chk("reset_in", obs_word(), 32'd0);
      i_rst = 1'b0;
      @(negedge clk);
      chk("reset_out", obs_word(), 32'd0);

      // Reference frame: 10x10 line-index pattern, frame_done position.
      single_frame(10, 10, 0, 1'b0);
      exp_q.delete();
      add_frame(10, 10, 0);
      kick(10, 10, 0, 1'b0);
      run_stream(exp_q.size(), 1'b0, 0, -1);
      chk("fd_latency", 32'(fd_idx),
          32'(P_VSYNC + P_VBACK + 10 * (2 * 10 + P_HBLANK) + P_VFRONT - 1));
      @(negedge clk);
      chk("busy_fall", obs_word(), 32'd0);

      // Gray ramp, short and full-width (x=255 must give FF,FF).
      single_frame(4, 1, 1, 1'b0);
      single_frame(256, 1, 1, 1'b0);
      // Checkerboard, phase flips at line 8.
      single_frame(32, 16, 3, 1'b0);
      // Colour bars across all eight bars plus wrap.
      single_frame(140, 2, 2, 1'b0);

      // Zero dimension blocks start.
      @(negedge clk);
      i_cmos_h = 16'd5;
      i_cmos_v = 16'd0;
      i_start  = 1'b1;
      idle_check("zero_v", 10);
      @(negedge clk);
      i_cmos_h = 16'd0;
      i_cmos_v = 16'd3;
      i_start  = 1'b1;
      idle_check("zero_h", 10);

      // Three back-to-back frames, cont dropped during the third.
      exp_q.delete();
      add_frame(12, 3, 2);
      len1 = exp_q.size();
      add_frame(12, 3, 2);
      add_frame(12, 3, 2);
      $display("cont run h=12 v=3 pat=2 frames=3 cycles=%0d", exp_q.size());
      kick(12, 3, 2, 1'b1);
      run_stream(exp_q.size(), 1'b1, len1 / 2, 2 * len1 + 50);
      @(negedge clk);
      chk("cont_end", obs_word(), 32'd0);

      // Reset during line 5.
      exp_q.delete();
      add_frame(10, 8, 3);
      line5 = P_VSYNC + P_VBACK + 5 * (2 * 10 + P_HBLANK);
      $display("reset test h=10 v=8 pat=3 rst_at=%0d", line5 + 3);
      kick(10, 8, 3, 1'b0);
      run_stream(line5 + 4, 1'b0, 0, -1);
      #2;
      i_rst = 1'b1;
      #1;
      chk("rst_async", obs_word(), 32'd0);
      @(negedge clk);
      i_rst = 1'b0;
      idle_check("rst_idle", 20);
      single_frame(10, 8, 3, 1'b0);

      // Randomized frames with scrambled inputs and stray start pulses.
      for (int t = 0; t < 6; t++) begin
         single_frame($urandom_range(1, 40), $urandom_range(1, 5),
                      $urandom_range(0, 3), 1'b1);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
